// File: rtl/ysyx_22040365_memwb_pipe.sv
// MEM/WB pipeline register with valid/ready handshake, optional two-entry skid
// buffer so in_ready never depends combinationally on out_ready.
module ysyx_22040365_memwb_pipe #(
   parameter int XLEN    = 64,
   parameter int ILEN    = 32,
   parameter int RA_W    = 5,
   parameter bit SKID_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] result_i,
   input  logic            rd_en_i,
   input  logic [RA_W-1:0] rd_addr_i,
   input  logic [ILEN-1:0] inst_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_o,
   output logic            rd_en_o,
   output logic [RA_W-1:0] rd_addr_o,
   output logic [ILEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o,
   output logic [1:0]      occ,
   output logic [63:0]     retire_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic            in_xfer, out_xfer, skid_valid;
   logic            load_main_in, load_main_skid, load_skid;
   logic            main_rd_en;
   logic [XLEN-1:0] skid_result, skid_pc;
   logic            skid_rd_en;
   logic [RA_W-1:0] skid_rd_addr;
   logic [ILEN-1:0] skid_inst;

   assign out_valid  = (state_q != S_EMPTY);
   assign skid_valid = (state_q == S_FULL);
   assign occ        = state_q;
   assign rd_en_o    = main_rd_en & out_valid;
   assign in_xfer    = in_valid & in_ready;
   assign out_xfer   = out_valid & out_ready;

   // The skid variant decouples in_ready from downstream; the plain register
   // variant can only accept when it empties in the same cycle.
   generate
      if (SKID_EN) begin : g_skid_ready
         assign in_ready = ~skid_valid;
      end else begin : g_reg_ready
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_EMPTY;
      else     state_q <= state_d;
   end

   // Flush wins over every transfer; payload loads are suppressed with it so
   // discarded entries cannot leak into the registers.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_xfer) begin
                  load_main_in = 1'b1;
                  state_d      = S_ONE;
               end
            end
            S_ONE: begin
               if (in_xfer && out_xfer) begin
                  load_main_in = 1'b1;
               end else if (in_xfer && SKID_EN) begin
                  load_skid = 1'b1;
                  state_d   = S_FULL;
               end else if (out_xfer) begin
                  state_d = S_EMPTY;
               end
            end
            S_FULL: begin
               if (out_xfer) begin
                  load_main_skid = 1'b1;
                  state_d        = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_o   <= '0;
         main_rd_en <= 1'b0;
         rd_addr_o  <= '0;
         inst_o     <= '0;
         pc_o       <= '0;
      end else if (load_main_in) begin
         result_o   <= result_i;
         main_rd_en <= rd_en_i;
         rd_addr_o  <= rd_addr_i;
         inst_o     <= inst_i;
         pc_o       <= pc_i;
      end else if (load_main_skid) begin
         result_o   <= skid_result;
         main_rd_en <= skid_rd_en;
         rd_addr_o  <= skid_rd_addr;
         inst_o     <= skid_inst;
         pc_o       <= skid_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skid_result  <= '0;
         skid_rd_en   <= 1'b0;
         skid_rd_addr <= '0;
         skid_inst    <= '0;
         skid_pc      <= '0;
      end else if (load_skid) begin
         skid_result  <= result_i;
         skid_rd_en   <= rd_en_i;
         skid_rd_addr <= rd_addr_i;
         skid_inst    <= inst_i;
         skid_pc      <= pc_i;
      end
   end

   // A transfer that coincides with flush was never really retired.
   always_ff @(posedge clk) begin
      if (rst)                    retire_cnt <= '0;
      else if (out_xfer && !flush) retire_cnt <= retire_cnt + 64'd1;
   end

endmodule

// File: tb/tb_ysyx_22040365_memwb_pipe.sv
// Randomised bench for the MEM/WB pipe: both skid and plain-register variants
// are driven together and compared against FIFO queue models.
module tb_ysyx_22040365_memwb_pipe;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [63:0] result_i, pc_i;
   logic        rd_en_i;
   logic [4:0]  rd_addr_i;
   logic [31:0] inst_i;

   logic        s_in_ready, s_out_valid, s_rd_en_o;
   logic [63:0] s_result_o, s_pc_o, s_retire_cnt;
   logic [4:0]  s_rd_addr_o;
   logic [31:0] s_inst_o;
   logic [1:0]  s_occ;

   logic        r_in_ready, r_out_valid, r_rd_en_o;
   logic [63:0] r_result_o, r_pc_o, r_retire_cnt;
   logic [4:0]  r_rd_addr_o;
   logic [31:0] r_inst_o;
   logic [1:0]  r_occ;

   typedef struct packed {
      logic [63:0] result;
      logic        rd_en;
      logic [4:0]  rd_addr;
      logic [31:0] inst;
      logic [63:0] pc;
   } entry_t;

   entry_t      q_skid[$];
   entry_t      q_reg[$];
   logic [63:0] cnt_skid, cnt_reg;
   int          check_cnt = 0;
   int          error_cnt = 0;

   always #5 clk = ~clk;

   ysyx_22040365_memwb_pipe #(.XLEN(64), .ILEN(32), .RA_W(5), .SKID_EN(1'b1)) dut_skid (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
      .result_i(result_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .inst_i(inst_i), .pc_i(pc_i),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .result_o(s_result_o), .rd_en_o(s_rd_en_o), .rd_addr_o(s_rd_addr_o), .inst_o(s_inst_o),
      .pc_o(s_pc_o), .occ(s_occ), .retire_cnt(s_retire_cnt)
   );

   ysyx_22040365_memwb_pipe #(.XLEN(64), .ILEN(32), .RA_W(5), .SKID_EN(1'b0)) dut_reg (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r_in_ready),
      .result_i(result_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .inst_i(inst_i), .pc_i(pc_i),
      .out_valid(r_out_valid), .out_ready(out_ready),
      .result_o(r_result_o), .rd_en_o(r_rd_en_o), .rd_addr_o(r_rd_addr_o), .inst_o(r_inst_o),
      .pc_o(r_pc_o), .occ(r_occ), .retire_cnt(r_retire_cnt)
   );

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      check_cnt++;
      if (act !== exp) begin
         error_cnt++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic compareDut(input string tag, input int size, input entry_t head,
                             input logic [63:0] cnt_exp, input logic rdy_exp,
                             input logic ov, input logic [1:0] oc, input logic ir,
                             input logic [63:0] rc, input logic re, input logic [63:0] res,
                             input logic [4:0] ra, input logic [31:0] ins, input logic [63:0] pc);
      checkOutput({tag, ".out_valid"}, 64'(ov), 64'(size > 0));
      checkOutput({tag, ".occ"}, 64'(oc), 64'(size));
      checkOutput({tag, ".in_ready"}, 64'(ir), 64'(rdy_exp));
      checkOutput({tag, ".retire_cnt"}, rc, cnt_exp);
      checkOutput({tag, ".rd_en_o"}, 64'(re), (size > 0) ? 64'(head.rd_en) : 64'd0);
      if (size > 0) begin
         checkOutput({tag, ".result_o"}, res, head.result);
         checkOutput({tag, ".rd_addr_o"}, 64'(ra), 64'(head.rd_addr));
         checkOutput({tag, ".inst_o"}, 64'(ins), 64'(head.inst));
         checkOutput({tag, ".pc_o"}, pc, head.pc);
      end
   endtask

   function automatic entry_t randEntry();
      entry_t e;
      e.result  = {$urandom, $urandom};
      e.rd_en   = 1'($urandom);
      e.rd_addr = 5'($urandom);
      e.inst    = $urandom;
      e.pc      = {$urandom, $urandom};
      return e;
   endfunction

   // One clock cycle: drive, check the registered state at negedge, then
   // advance both queue models with what the edge sampled.
   task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                input logic orr, input entry_t e);
      logic   rdy_s, rdy_r, ix_s, ox_s, ix_r, ox_r;
      entry_t head;
      rst = r; flush = f; in_valid = iv; out_ready = orr;
      result_i = e.result; rd_en_i = e.rd_en; rd_addr_i = e.rd_addr;
      inst_i = e.inst; pc_i = e.pc;
      @(negedge clk);
      rdy_s = (q_skid.size() < 2);
      rdy_r = (q_reg.size() == 0) || orr;
      head = (q_skid.size() > 0) ? q_skid[0] : '0;
      compareDut("skid", q_skid.size(), head, cnt_skid, rdy_s, s_out_valid, s_occ, s_in_ready,
                 s_retire_cnt, s_rd_en_o, s_result_o, s_rd_addr_o, s_inst_o, s_pc_o);
      head = (q_reg.size() > 0) ? q_reg[0] : '0;
      compareDut("reg", q_reg.size(), head, cnt_reg, rdy_r, r_out_valid, r_occ, r_in_ready,
                 r_retire_cnt, r_rd_en_o, r_result_o, r_rd_addr_o, r_inst_o, r_pc_o);
      ix_s = iv & rdy_s;  ox_s = (q_skid.size() > 0) & orr;
      ix_r = iv & rdy_r;  ox_r = (q_reg.size() > 0) & orr;
      @(posedge clk);
      if (r) begin
         q_skid.delete(); q_reg.delete(); cnt_skid = '0; cnt_reg = '0;
      end else if (f) begin
         q_skid.delete(); q_reg.delete();
      end else begin
         if (ox_s) begin void'(q_skid.pop_front()); cnt_skid++; end
         if (ix_s) q_skid.push_back(e);
         if (ox_r) begin void'(q_reg.pop_front()); cnt_reg++; end
         if (ix_r) q_reg.push_back(e);
      end
      #1;
   endtask

   initial begin
      entry_t e;
      cnt_skid = '0; cnt_reg = '0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      result_i = '0; rd_en_i = 1'b0; rd_addr_i = '0; inst_i = '0; pc_i = '0;
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, randEntry());

      checkOutput("rst.s_pc_o", s_pc_o, 64'd0);
      checkOutput("rst.s_result_o", s_result_o, 64'd0);
      checkOutput("rst.s_inst_o", 64'(s_inst_o), 64'd0);
      checkOutput("rst.s_rd_addr_o", 64'(s_rd_addr_o), 64'd0);
      checkOutput("rst.s_in_ready", 64'(s_in_ready), 64'd1);
      checkOutput("rst.r_in_ready", 64'(r_in_ready), 64'd1);

      // Streaming at full rate
      for (int k = 0; k < 8; k++) begin
         e = randEntry();
         e.pc = 64'h8000_0000 + 64'(4 * k);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, e);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, randEntry());
      checkOutput("stream.s_retire", s_retire_cnt, 64'd8);
      checkOutput("stream.r_retire", r_retire_cnt, 64'd8);

      // Backpressure fills the skid variant
      e = randEntry(); e.pc = 64'h1000;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, e);
      e = randEntry(); e.pc = 64'h2000;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, e);
      checkOutput("bp.s_occ", 64'(s_occ), 64'd2);
      checkOutput("bp.s_in_ready", 64'(s_in_ready), 64'd0);
      checkOutput("bp.s_pc_o", s_pc_o, 64'h1000);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, randEntry());
      checkOutput("bp.s_pc_o2", s_pc_o, 64'h2000);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, randEntry());
      checkOutput("bp.s_occ0", 64'(s_occ), 64'd0);
      checkOutput("bp.s_retire", s_retire_cnt, 64'd10);

      // Flush while full, with a new entry offered in the same cycle
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randEntry());
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randEntry());
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, randEntry());
      checkOutput("flush.s_occ", 64'(s_occ), 64'd0);
      checkOutput("flush.s_out_valid", 64'(s_out_valid), 64'd0);
      checkOutput("flush.s_rd_en_o", 64'(s_rd_en_o), 64'd0);
      checkOutput("flush.s_retire", s_retire_cnt, 64'd10);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, randEntry());

      // Bubble must not write back; a real entry must
      e = randEntry(); e.rd_en = 1'b1; e.rd_addr = 5'd5;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, e);
      e.result = 64'hDEAD;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, e);
      checkOutput("bubble.s_rd_en_o", 64'(s_rd_en_o), 64'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, randEntry());
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, randEntry());
      checkOutput("bubble.s_rd_en_o0", 64'(s_rd_en_o), 64'd0);

      // Reset in the middle of operation
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randEntry());
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, randEntry());
      checkOutput("midrst.s_occ", 64'(s_occ), 64'd0);
      checkOutput("midrst.s_retire", s_retire_cnt, 64'd0);
      checkOutput("midrst.s_pc_o", s_pc_o, 64'd0);
      checkOutput("midrst.r_in_ready", 64'(r_in_ready), 64'd1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6, randEntry());
      end

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
      $finish;
   end

endmodule
